// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter for a single-port data memory shared by two requesters.
// gnt one cycle after req is sampled, read data/rvalid one cycle later; req must be held until gnt.
module data_mem_arbiter #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_write_data,
  output logic          mem_wren,
  input  logic [DW-1:0] mem_read_data
);

  typedef enum logic {IDLE, ACC} state_t;

  state_t state, state_nxt;
  logic   grant_vld;
  logic   win_sel;
  logic   last_winner;
  logic   cmd_we;
  logic   cmd_port;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant_vld = 1'b0;
    // On a tie the port that did not win last time goes first.
    if (req0 && req1) win_sel = ~last_winner;
    else              win_sel = req1;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          state_nxt = ACC;
          grant_vld = 1'b1;
        end
      end
      ACC:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt0           <= 1'b0;
      gnt1           <= 1'b0;
      rvalid0        <= 1'b0;
      rvalid1        <= 1'b0;
      rdata          <= '0;
      mem_address    <= '0;
      mem_write_data <= '0;
      last_winner    <= 1'b1;
      cmd_we         <= 1'b0;
      cmd_port       <= 1'b0;
    end else begin
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      if (grant_vld) begin
        last_winner    <= win_sel;
        cmd_port       <= win_sel;
        cmd_we         <= win_sel ? we1 : we0;
        mem_address    <= win_sel ? addr1 : addr0;
        mem_write_data <= win_sel ? wdata1 : wdata0;
        gnt0           <= ~win_sel;
        gnt1           <= win_sel;
      end
      if (state == ACC && !cmd_we) begin
        rdata   <= mem_read_data;
        rvalid0 <= ~cmd_port;
        rvalid1 <= cmd_port;
      end
    end
  end

  assign busy = (state == ACC);
  // rst gates the strobe directly so a reset landing mid-access drops the write.
  assign mem_wren = (state == ACC) ? ~(cmd_we & ~rst) : 1'b1;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: behavioural 256x8 memory, read scoreboard, directed steps.
module tb_data_mem_arbiter;

  typedef struct packed {
    logic       port;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, we0, req1, we1;
  logic [7:0] addr0, wdata0, addr1, wdata1;
  logic       gnt0, gnt1, rvalid0, rvalid1, busy, mem_wren;
  logic [7:0] rdata, mem_address, mem_write_data, mem_read_data;

  logic [7:0] mem     [256];
  logic [7:0] exp_mem [256];
  exp_t       sb [$];
  logic [7:0] exp_rdata;
  logic       lw;
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  data_mem_arbiter #(.AW(8), .DW(8)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .busy(busy),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_wren(mem_wren), .mem_read_data(mem_read_data)
  );

  always @(posedge clk) if (mem_wren === 1'b0) mem[mem_address] <= mem_write_data;
  assign mem_read_data = mem[mem_address];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    chk("gnt_excl", {31'd0, gnt0 & gnt1}, 32'd0);
    if (rvalid0 === 1'b1 || rvalid1 === 1'b1) begin
      chk("rvalid_excl", {31'd0, rvalid0 & rvalid1}, 32'd0);
      if (sb.size() == 0) begin
        chk("rvalid_unexpected", {30'd0, rvalid1, rvalid0}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("rv_port", {31'd0, rvalid1}, {31'd0, e.port});
        chk("rv_data", {24'd0, rdata}, {24'd0, e.data});
      end
    end
  end

  // Single access issued from IDLE; checks gnt cycle and the following cycle.
  task automatic access(input bit p, input bit w, input logic [7:0] a, input logic [7:0] d);
    if (p) begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; req0 = 1'b0; end
    else   begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; req1 = 1'b0; end
    if (w) exp_mem[a] = d;
    else begin
      sb.push_back('{port: p, data: exp_mem[a]});
      exp_rdata = exp_mem[a];
    end
    @(negedge clk);
    chk("acc_gnt_win", {31'd0, p ? gnt1 : gnt0}, 32'd1);
    chk("acc_gnt_other", {31'd0, p ? gnt0 : gnt1}, 32'd0);
    chk("acc_busy", {31'd0, busy}, 32'd1);
    chk("acc_wren", {31'd0, mem_wren}, {31'd0, ~w});
    chk("acc_addr", {24'd0, mem_address}, {24'd0, a});
    if (w) chk("acc_wdata", {24'd0, mem_write_data}, {24'd0, d});
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);
    chk("post_busy", {31'd0, busy}, 32'd0);
    chk("post_wren", {31'd0, mem_wren}, 32'd1);
    chk("post_rvalid", {31'd0, p ? rvalid1 : rvalid0}, {31'd0, ~w});
    if (w) chk("post_rdata_hold", {24'd0, rdata}, {24'd0, exp_rdata});
    lw = p;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 8'(i * 3) ^ 8'h5A;
      exp_mem[i] = 8'(i * 3) ^ 8'h5A;
    end
    rst = 1'b1;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    lw = 1'b1;
    exp_rdata = '0;

    // Reset held for two cycles
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("rst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
      chk("rst_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
      chk("rst_rdata", {24'd0, rdata}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_addr", {24'd0, mem_address}, 32'd0);
      chk("rst_wdata", {24'd0, mem_write_data}, 32'd0);
      chk("rst_wren", {31'd0, mem_wren}, 32'd1);
    end
    rst = 1'b0;

    // Write then read back from the other port
    access(1'b0, 1'b1, 8'h05, 8'h21);
    access(1'b1, 1'b0, 8'h05, 8'h00);

    // Both ports requesting continuously: strict alternation starting at port 0
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h00;
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h01;
    for (int i = 0; i < 4; i++) begin
      bit win;
      win = (i % 2) == 1;
      sb.push_back('{port: win, data: exp_mem[win ? 8'h01 : 8'h00]});
      exp_rdata = exp_mem[win ? 8'h01 : 8'h00];
      @(negedge clk);
      chk("rr_gnt0", {31'd0, gnt0}, {31'd0, ~win});
      chk("rr_gnt1", {31'd0, gnt1}, {31'd0, win});
      chk("rr_busy_hi", {31'd0, busy}, 32'd1);
      @(negedge clk);
      chk("rr_busy_lo", {31'd0, busy}, 32'd0);
      chk("rr_rvalid", {30'd0, rvalid1, rvalid0}, win ? 32'd2 : 32'd1);
      lw = win;
    end
    req0 = 1'b0;
    req1 = 1'b0;

    // Port 0 alone, held: grant every other cycle
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h10;
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{port: 1'b0, data: exp_mem[8'h10]});
      exp_rdata = exp_mem[8'h10];
      @(negedge clk);
      chk("solo_gnt_hi", {31'd0, gnt0}, 32'd1);
      chk("solo_busy_hi", {31'd0, busy}, 32'd1);
      @(negedge clk);
      chk("solo_gnt_lo", {31'd0, gnt0}, 32'd0);
      chk("solo_busy_lo", {31'd0, busy}, 32'd0);
    end
    req0 = 1'b0;
    lw = 1'b0;

    // Reset during a write's access cycle drops the write
    access(1'b0, 1'b1, 8'h02, 8'h65);
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h02; wdata0 = 8'h87;
    @(negedge clk);
    chk("mr_gnt", {31'd0, gnt0}, 32'd1);
    chk("mr_wren_pre", {31'd0, mem_wren}, 32'd0);
    req0 = 1'b0;
    rst = 1'b1;
    #1;
    chk("mr_wren_rst", {31'd0, mem_wren}, 32'd1);
    @(negedge clk);
    chk("mr_busy", {31'd0, busy}, 32'd0);
    chk("mr_gnt_after", {30'd0, gnt1, gnt0}, 32'd0);
    chk("mr_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
    chk("mr_rdata", {24'd0, rdata}, 32'd0);
    rst = 1'b0;
    lw = 1'b1;
    exp_rdata = '0;
    access(1'b1, 1'b0, 8'h02, 8'h00);

    // Write on port 0, read on port 1 in the next slot
    access(1'b0, 1'b1, 8'h03, 8'hA9);
    access(1'b1, 1'b0, 8'h03, 8'h00);

    // Top address passes straight through
    access(1'b1, 1'b1, 8'hFF, 8'h3C);
    access(1'b0, 1'b0, 8'hFF, 8'h00);

    @(negedge clk);
    chk("sb_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
